// File: rtl/if_prefetch_queue.sv
// Sequential instruction prefetch into a small {pc, instr} FIFO feeding
// decode; a taken branch flushes the queue and restarts fetch at the target.
module if_prefetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  localparam int         AW       = $clog2(DEPTH),
  localparam int         CW       = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  output logic          mem_req,
  output logic [31:0]   mem_addr,
  input  logic          mem_ack,
  input  logic [31:0]   mem_rdata,
  input  logic          redirect,
  input  logic [31:0]   redirect_pc,
  input  logic          inst_ready,
  output logic          inst_valid,
  output logic [31:0]   inst,
  output logic [31:0]   pc_out,
  output logic [31:0]   pc_4_out,
  output logic [CW-1:0] count
);
  typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;

  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  state_t        state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   hold_pc_q, hold_pc_d;
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   pc_q  [DEPTH];
  logic [31:0]   pc_d  [DEPTH];
  logic [31:0]   ins_q [DEPTH];
  logic [31:0]   ins_d [DEPTH];
  logic          push, pop, valid;
  logic [31:0]   target;
  logic          unused_rpc;

  assign target     = {redirect_pc[31:2], 2'b00};
  assign unused_rpc = ^redirect_pc[1:0];
  assign valid      = count_q != '0;
  assign push       = state_q == REQ && mem_ack && !redirect;
  assign pop        = valid && inst_ready && !redirect;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      hold_pc_q  <= RESET_PC;
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_q[i]  <= '0;
        ins_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      hold_pc_q  <= hold_pc_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      for (int i = 0; i < DEPTH; i++) begin
        pc_q[i]  <= pc_d[i];
        ins_q[i] <= ins_d[i];
      end
    end
  end

  // The abandoned request keeps its address on the bus until its ack.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    hold_pc_d  = hold_pc_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    count_d    = count_q;
    pc_d       = pc_q;
    ins_d      = ins_q;
    if (state_q == REQ && redirect && !mem_ack)
      hold_pc_d = fetch_pc_q;
    if (redirect) begin
      fetch_pc_d = target;
      wptr_d     = '0;
      rptr_d     = '0;
      count_d    = '0;
    end else begin
      if (push) begin
        pc_d[wptr_q]  = fetch_pc_q;
        ins_d[wptr_q] = mem_rdata;
        wptr_d        = wptr_q + AW'(1);
        fetch_pc_d    = fetch_pc_q + 32'd4;
      end
      if (pop)
        rptr_d = rptr_q + AW'(1);
      if (push && !pop)
        count_d = count_q + CW'(1);
      else if (pop && !push)
        count_d = count_q - CW'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:
        if (count_q < FULL && !redirect)
          state_d = REQ;
      REQ:
        if (redirect)
          state_d = mem_ack ? IDLE : DROP;
        else if (mem_ack)
          state_d = (count_d < FULL) ? REQ : IDLE;
      DROP:
        if (mem_ack)
          state_d = IDLE;
      default:
        state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_req    = state_q == REQ || state_q == DROP;
    mem_addr   = (state_q == DROP) ? hold_pc_q : fetch_pc_q;
    inst_valid = valid;
    inst       = valid ? ins_q[rptr_q] : '0;
    pc_out     = valid ? pc_q[rptr_q] : '0;
    pc_4_out   = valid ? pc_q[rptr_q] + 32'd4 : '0;
    count      = count_q;
  end
endmodule

// File: tb/tb_if_prefetch_queue.sv
// Directed bench for if_prefetch_queue: streaming, backpressure, redirect
// during wait and on ack, async reset, and pc wrap at the top of memory.
module tb_if_prefetch_queue;
  logic        clk;
  logic        rst;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        inst_ready;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] pc_out;
  logic [31:0] pc_4_out;
  logic [2:0]  count;

  logic        mem_req2;
  logic [31:0] mem_addr2;
  logic        inst_valid2;
  logic [31:0] inst2;
  logic [31:0] pc_out2;
  logic [31:0] pc_4_out2;
  logic [2:0]  count2;

  int          tests;
  int          fails;
  int          lat;
  logic [3:0]  wcnt;

  if_prefetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst),
    .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .inst_ready(inst_ready), .inst_valid(inst_valid),
    .inst(inst), .pc_out(pc_out), .pc_4_out(pc_4_out),
    .count(count)
  );

  if_prefetch_queue #(.DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) dut2 (
    .clk(clk), .rst(rst),
    .mem_req(mem_req2), .mem_addr(mem_addr2),
    .mem_ack(mem_req2), .mem_rdata(mem_addr2 ^ 32'hA5A5_0000),
    .redirect(1'b0), .redirect_pc(32'h0),
    .inst_ready(1'b1), .inst_valid(inst_valid2),
    .inst(inst2), .pc_out(pc_out2), .pc_4_out(pc_4_out2),
    .count(count2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // memory: ack after `lat` wait cycles of a continuous request
  assign mem_ack   = mem_req && (wcnt == lat[3:0]);
  assign mem_rdata = mem_addr ^ 32'hA5A5_0000;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      wcnt <= '0;
    else if (mem_req && !mem_ack)
      wcnt <= wcnt + 4'd1;
    else
      wcnt <= '0;
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    redirect = 1'b0;
    step;
    step;
    rst = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    step;
    tests++;
    if (mem_req !== 1'b0) begin
      fails++; $display("FAIL reset_mem_req got %b exp 0", mem_req);
    end
    tests++;
    if ({inst_valid, inst, pc_out, pc_4_out, count} !== '0) begin
      fails++;
      $display("FAIL reset_outs got v=%b i=%h p=%h p4=%h c=%0d exp all 0",
               inst_valid, inst, pc_out, pc_4_out, count);
    end
    tests++;
    if (mem_addr !== 32'h0) begin
      fails++; $display("FAIL reset_addr got %h exp 00000000", mem_addr);
    end
    tests++;
    if (mem_addr2 !== 32'hFFFF_FFF8) begin
      fails++; $display("FAIL reset_addr2 got %h exp fffffff8", mem_addr2);
    end
  endtask

  task automatic test_stream;
    logic [31:0] e;
    lat = 0;
    inst_ready = 1'b1;
    do_reset;
    step;
    tests++;
    if ({inst_valid, mem_req} !== 2'b01) begin
      fails++; $display("FAIL stream_first got v=%b req=%b exp v=0 req=1",
                        inst_valid, mem_req);
    end
    for (int k = 0; k < 8; k++) begin
      step;
      e = 32'(k) * 32'd4;
      tests++;
      if (inst_valid !== 1'b1 || pc_out !== e) begin
        fails++; $display("FAIL stream_pc k=%0d got v=%b %h exp %h",
                          k, inst_valid, pc_out, e);
      end
      tests++;
      if (inst !== (e ^ 32'hA5A5_0000) || pc_4_out !== e + 32'd4) begin
        fails++; $display("FAIL stream_data k=%0d got %h %h exp %h %h",
                          k, inst, pc_4_out, e ^ 32'hA5A5_0000, e + 32'd4);
      end
      tests++;
      if (count !== 3'd1) begin
        fails++; $display("FAIL stream_count k=%0d got %0d exp 1", k, count);
      end
    end
  endtask

  task automatic test_backpressure;
    logic [31:0] e;
    lat = 0;
    inst_ready = 1'b0;
    do_reset;
    repeat (10) step;
    tests++;
    if (count !== 3'd4 || mem_req !== 1'b0) begin
      fails++; $display("FAIL bp_full got c=%0d req=%b exp c=4 req=0",
                        count, mem_req);
    end
    tests++;
    if (mem_addr !== 32'd16 || pc_out !== 32'd0 || inst_valid !== 1'b1) begin
      fails++; $display("FAIL bp_hold got addr=%h pc=%h v=%b exp 10 0 1",
                        mem_addr, pc_out, inst_valid);
    end
    inst_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      e = 32'(k) * 32'd4;
      tests++;
      if (inst_valid !== 1'b1 || pc_out !== e) begin
        fails++; $display("FAIL bp_drain k=%0d got v=%b %h exp %h",
                          k, inst_valid, pc_out, e);
      end
      step;
    end
  endtask

  task automatic test_drop;
    logic got;
    lat = 3;
    inst_ready = 1'b1;
    do_reset;
    step;
    step;
    redirect = 1'b1;
    redirect_pc = 32'h0000_0103;
    tests++;
    if ({mem_req, mem_ack} !== 2'b10) begin
      fails++; $display("FAIL drop_wait got req=%b ack=%b exp 1 0",
                        mem_req, mem_ack);
    end
    step;
    redirect = 1'b0;
    tests++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h0) begin
      fails++; $display("FAIL drop_hold got req=%b addr=%h exp 1 0",
                        mem_req, mem_addr);
    end
    step;
    tests++;
    if (mem_ack !== 1'b1 || mem_addr !== 32'h0) begin
      fails++; $display("FAIL drop_ack got ack=%b addr=%h exp 1 0",
                        mem_ack, mem_addr);
    end
    step;
    tests++;
    if (mem_req !== 1'b0 || inst_valid !== 1'b0) begin
      fails++; $display("FAIL drop_discard got req=%b v=%b exp 0 0",
                        mem_req, inst_valid);
    end
    step;
    tests++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h100) begin
      fails++; $display("FAIL drop_refetch got req=%b addr=%h exp 1 100",
                        mem_req, mem_addr);
    end
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      step;
      got = inst_valid;
    end
    tests++;
    if (!got || pc_out !== 32'h100 || inst !== (32'h100 ^ 32'hA5A5_0000)) begin
      fails++; $display("FAIL drop_first got v=%b pc=%h i=%h exp 1 100 a5a50100",
                        got, pc_out, inst);
    end
  endtask

  task automatic test_redirect_collide;
    lat = 0;
    inst_ready = 1'b1;
    do_reset;
    repeat (4) step;
    redirect = 1'b1;
    redirect_pc = 32'h0000_0200;
    tests++;
    if ({inst_valid, mem_ack} !== 2'b11) begin
      fails++; $display("FAIL coll_pre got v=%b ack=%b exp 1 1",
                        inst_valid, mem_ack);
    end
    step;
    redirect = 1'b0;
    tests++;
    if (inst_valid !== 1'b0 || count !== 3'd0) begin
      fails++; $display("FAIL coll_flush got v=%b c=%0d exp 0 0",
                        inst_valid, count);
    end
    tests++;
    if (mem_addr !== 32'h200 || mem_req !== 1'b0) begin
      fails++; $display("FAIL coll_addr got addr=%h req=%b exp 200 0",
                        mem_addr, mem_req);
    end
    step;
    step;
    tests++;
    if (inst_valid !== 1'b1 || pc_out !== 32'h200) begin
      fails++; $display("FAIL coll_target got v=%b pc=%h exp 1 200",
                        inst_valid, pc_out);
    end
  endtask

  task automatic test_async_reset;
    logic got;
    lat = 3;
    inst_ready = 1'b0;
    do_reset;
    repeat (9) step;
    tests++;
    if (count !== 3'd2 || mem_req !== 1'b1) begin
      fails++; $display("FAIL arst_pre got c=%0d req=%b exp 2 1", count, mem_req);
    end
    #2 rst = 1'b1;
    #1;
    tests++;
    if (mem_req !== 1'b0 || inst_valid !== 1'b0 || count !== 3'd0) begin
      fails++; $display("FAIL arst_busy got req=%b v=%b c=%0d exp 0 0 0",
                        mem_req, inst_valid, count);
    end
    step;
    rst = 1'b0;
    step;
    step;
    redirect = 1'b1;
    redirect_pc = 32'h0000_0040;
    step;
    redirect = 1'b0;
    tests++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h0) begin
      fails++; $display("FAIL arst_drop got req=%b addr=%h exp 1 0",
                        mem_req, mem_addr);
    end
    #2 rst = 1'b1;
    #1;
    tests++;
    if (mem_req !== 1'b0 || mem_addr !== 32'h0) begin
      fails++; $display("FAIL arst_in_drop got req=%b addr=%h exp 0 0",
                        mem_req, mem_addr);
    end
    step;
    rst = 1'b0;
    step;
    tests++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h0) begin
      fails++; $display("FAIL arst_restart got req=%b addr=%h exp 1 0",
                        mem_req, mem_addr);
    end
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      step;
      got = inst_valid;
    end
    tests++;
    if (!got || pc_out !== 32'h0) begin
      fails++; $display("FAIL arst_first got v=%b pc=%h exp 1 0", got, pc_out);
    end
  endtask

  task automatic test_wrap;
    logic [31:0] ep [3];
    logic [31:0] e4 [3];
    ep[0] = 32'hFFFF_FFF8; e4[0] = 32'hFFFF_FFFC;
    ep[1] = 32'hFFFF_FFFC; e4[1] = 32'h0000_0000;
    ep[2] = 32'h0000_0000; e4[2] = 32'h0000_0004;
    lat = 0;
    do_reset;
    step;
    for (int k = 0; k < 3; k++) begin
      step;
      tests++;
      if (inst_valid2 !== 1'b1 || pc_out2 !== ep[k] || pc_4_out2 !== e4[k]) begin
        fails++; $display("FAIL wrap k=%0d got v=%b %h %h exp %h %h",
                          k, inst_valid2, pc_out2, pc_4_out2, ep[k], e4[k]);
      end
      tests++;
      if (inst2 !== (ep[k] ^ 32'hA5A5_0000) || count2 !== 3'd1) begin
        fails++; $display("FAIL wrap_data k=%0d got %h c=%0d exp %h 1",
                          k, inst2, count2, ep[k] ^ 32'hA5A5_0000);
      end
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    lat = 0;
    rst = 1'b1;
    redirect = 1'b0;
    redirect_pc = 32'h0;
    inst_ready = 1'b1;
    test_reset;
    test_stream;
    test_backpressure;
    test_drop;
    test_redirect_collide;
    test_async_reset;
    test_wrap;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
endmodule
